// File: rtl/ddr_channel_arbiter.sv
// ddr_channel_arbiter
// Arbitrates the IFU line-fetch channel and the LSU read/write channel onto
// a single simddr port. One DDR operation is in flight at a time. Grants
// alternate between the channels when both request. An IFU flush suppresses
// the IFU response, and a watchdog abandons DDR operations that never complete.
module ddr_channel_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 512,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ifu_req_valid,
  input  logic [ADDR_W-1:0] ifu_req_addr,
  output logic              ifu_req_ready,
  input  logic              ifu_flush,
  output logic              ifu_resp_valid,
  output logic [DATA_W-1:0] ifu_resp_data,
  input  logic              lsu_req_valid,
  input  logic              lsu_req_write,
  input  logic [ADDR_W-1:0] lsu_req_addr,
  input  logic [DATA_W-1:0] lsu_req_wmask,
  input  logic [DATA_W-1:0] lsu_req_wdata,
  output logic              lsu_req_ready,
  output logic              lsu_resp_valid,
  output logic [DATA_W-1:0] lsu_resp_data,
  output logic              ddr_chip_enable,
  output logic [ADDR_W-1:0] ddr_index,
  output logic              ddr_write_enable,
  output logic              ddr_burst_mode,
  output logic [DATA_W-1:0] ddr_write_mask,
  output logic [DATA_W-1:0] ddr_write_data,
  input  logic [DATA_W-1:0] ddr_read_data,
  input  logic              ddr_operation_done,
  input  logic              ddr_ready,
  output logic              watchdog_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              last_ifu;   // 1 when the most recent grant went to IFU
  logic              op_ifu;     // owner of the in-flight operation
  logic              ifu_drop;   // IFU response of the in-flight op is discarded
  logic [CNT_W-1:0]  wait_cnt;
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] ifu_hold;
  logic [DATA_W-1:0] lsu_hold;

  logic              ifu_ok;
  logic              grant_any;
  logic              grant_ifu;
  logic              timeout;
  logic              exit_busy;

  // A flushing IFU cannot be granted in the same cycle.
  assign ifu_ok    = ifu_req_valid & ~ifu_flush;
  assign exit_busy = (state != S_IDLE) && (state_nxt == S_IDLE);

  // Next-state, round-robin grant and combinational request handshakes.
  always_comb begin
    state_nxt     = state;
    grant_any     = 1'b0;
    grant_ifu     = 1'b0;
    timeout       = 1'b0;
    ifu_req_ready = 1'b0;
    lsu_req_ready = 1'b0;
    case (state)
      S_IDLE: begin
        // Nothing is accepted while reset is held, so no request is lost.
        if (reset && ddr_ready && (ifu_ok || lsu_req_valid)) begin
          grant_any     = 1'b1;
          grant_ifu     = (ifu_ok && lsu_req_valid) ? ~last_ifu : ifu_ok;
          ifu_req_ready = grant_ifu;
          lsu_req_ready = ~grant_ifu;
          state_nxt     = S_ISSUE;
        end
      end
      S_ISSUE: state_nxt = S_WAIT;
      S_WAIT: begin
        if (ddr_operation_done) begin
          state_nxt = S_RESP;
        end else if (wait_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          // Last permitted WAIT cycle without completion: abandon the op.
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Grant history, operation owner, flush-drop flag, watchdog counter and error.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_ifu     <= 1'b0;
      op_ifu       <= 1'b0;
      ifu_drop     <= 1'b0;
      wait_cnt     <= '0;
      watchdog_err <= 1'b0;
    end else begin
      if (grant_any) begin
        last_ifu <= grant_ifu;
        op_ifu   <= grant_ifu;
      end
      if (exit_busy)
        ifu_drop <= 1'b0;
      else if ((state != S_IDLE) && op_ifu && ifu_flush)
        ifu_drop <= 1'b1;
      if (state == S_WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      else                 wait_cnt <= '0;
      if (timeout) watchdog_err <= 1'b1;
    end
  end

  // DDR command fields: loaded at grant, held through the op, zeroed on return to IDLE.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ddr_index        <= '0;
      ddr_write_enable <= 1'b0;
      ddr_burst_mode   <= 1'b0;
      ddr_write_mask   <= '0;
      ddr_write_data   <= '0;
    end else if (grant_any) begin
      ddr_index        <= grant_ifu ? ifu_req_addr : lsu_req_addr;
      ddr_write_enable <= ~grant_ifu & lsu_req_write;
      ddr_burst_mode   <= grant_ifu;
      ddr_write_mask   <= (~grant_ifu & lsu_req_write) ? lsu_req_wmask : '0;
      ddr_write_data   <= (~grant_ifu & lsu_req_write) ? lsu_req_wdata : '0;
    end else if (exit_busy) begin
      ddr_index        <= '0;
      ddr_write_enable <= 1'b0;
      ddr_burst_mode   <= 1'b0;
      ddr_write_mask   <= '0;
      ddr_write_data   <= '0;
    end
  end

  // Capture completion data (zero for writes) and remember the last delivered responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rdata_q  <= '0;
      ifu_hold <= '0;
      lsu_hold <= '0;
    end else begin
      if ((state == S_WAIT) && ddr_operation_done)
        rdata_q <= ddr_write_enable ? '0 : ddr_read_data;
      if (ifu_resp_valid) ifu_hold <= rdata_q;
      if (lsu_resp_valid) lsu_hold <= rdata_q;
    end
  end

  assign ddr_chip_enable = (state == S_ISSUE);
  // A flush arriving in the response cycle itself still discards the line.
  assign ifu_resp_valid  = (state == S_RESP) && op_ifu && ~ifu_drop && ~ifu_flush;
  assign lsu_resp_valid  = (state == S_RESP) && ~op_ifu;
  assign ifu_resp_data   = ifu_resp_valid ? rdata_q : ifu_hold;
  assign lsu_resp_data   = lsu_resp_valid ? rdata_q : lsu_hold;

endmodule
